divider_pipeline: RTL and testbench



---
 rtl/divider_pipeline_if.sv | 34 +++
 rtl/divider_pipeline.sv | 135 +++++++++++++
 tb/tb_divider_pipeline.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/divider_pipeline_if.sv
// Operand/config/result bundle shared by the divider and its bus master.
// Latency: none, this is wiring only.
// Backpressure: none; every thread slot accepts an operand write each cycle.
interface divider_pipeline_if #(
    parameter int WORD_WIDTH        = 36,
    parameter int THREAD_COUNT      = 8,
    parameter int CONFIG_ADDR_WIDTH = 10
);
    localparam int TW = $clog2(THREAD_COUNT);

    logic [CONFIG_ADDR_WIDTH-1:0] config_addr;
    logic                         config_signed;
    logic                         config_enable;
    logic [WORD_WIDTH-1:0]        A;
    logic                         A_wren;
    logic [WORD_WIDTH-1:0]        B;
    logic                         B_wren;
    logic [WORD_WIDTH-1:0]        Q;
    logic [WORD_WIDTH-1:0]        R;
    logic                         busy;
    logic                         done;
    logic                         div_by_zero;
    logic [TW-1:0]                thread;

    modport master (
        output config_addr, config_signed, config_enable, A, A_wren, B, B_wren,
        input  Q, R, busy, done, div_by_zero, thread
    );

    modport slave (
        input  config_addr, config_signed, config_enable, A, A_wren, B, B_wren,
        output Q, R, busy, done, div_by_zero, thread
    );
endinterface

// File: rtl/divider_pipeline.sv
// Round-robin multithreaded radix-2 restoring divider, one step per thread visit.
// Latency: result visible (WORD_WIDTH+1)*THREAD_COUNT cycles after start; B==0 after THREAD_COUNT.
// Backpressure: none; a start while busy aborts and restarts that thread.
module divider_pipeline #(
    parameter int WORD_WIDTH        = 36,
    parameter int THREAD_COUNT      = 8,
    parameter int CONFIG_ADDR       = 0,
    parameter int CONFIG_ADDR_WIDTH = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    divider_pipeline_if.slave  bus
);
    localparam int W  = WORD_WIDTH;
    localparam int TW = $clog2(THREAD_COUNT);
    localparam int CW = $clog2(WORD_WIDTH + 1);

    // Per-thread state. The stored remainder is always below the divisor, so
    // W bits hold it; the extra bit only exists in the shifted trial value.
    logic [TW-1:0] thr;
    logic          signed_mode [THREAD_COUNT];
    logic [W-1:0]  a_latch     [THREAD_COUNT];
    logic [W-1:0]  divisor     [THREAD_COUNT];
    logic [W-1:0]  rem         [THREAD_COUNT];
    logic [W-1:0]  quo         [THREAD_COUNT];
    logic [CW-1:0] step_cnt    [THREAD_COUNT];
    logic          q_neg       [THREAD_COUNT];
    logic          r_neg       [THREAD_COUNT];
    logic          running     [THREAD_COUNT];
    logic          finished    [THREAD_COUNT];
    logic          zero_div    [THREAD_COUNT];

    logic          cfg_hit;
    logic [W-1:0]  dividend;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    shifted;
    logic          fits;
    logic [W-1:0]  diff;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  quo_nx;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    // Start operand preparation and the single shared restoring step for the slot's thread.
    always_comb begin
        cfg_hit  = bus.config_enable && (bus.config_addr == CONFIG_ADDR_WIDTH'(CONFIG_ADDR));
        dividend = bus.A_wren ? bus.A : a_latch[thr];
        // The start always uses the flag as it stood before this cycle's config write.
        a_neg    = signed_mode[thr] & dividend[W-1];
        b_neg    = signed_mode[thr] & bus.B[W-1];
        a_mag    = a_neg ? -dividend : dividend;
        b_mag    = b_neg ? -bus.B : bus.B;
        shifted  = {rem[thr], quo[thr][W-1]};
        fits     = shifted >= {1'b0, divisor[thr]};
        // The true difference is below 2^W whenever fits is set, so W bits suffice.
        diff     = shifted[W-1:0] - divisor[thr];
        rem_nx   = fits ? diff : shifted[W-1:0];
        quo_nx   = {quo[thr][W-2:0], fits};
        q_fix    = q_neg[thr] ? -quo_nx : quo_nx;
        r_fix    = r_neg[thr] ? -rem_nx : rem_nx;
    end

    // Thread slot advance, config/operand capture, start and per-visit stepping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            thr <= '0;
            for (int i = 0; i < THREAD_COUNT; i++) begin
                signed_mode[i] <= 1'b0;
                a_latch[i]     <= '0;
                divisor[i]     <= '0;
                rem[i]         <= '0;
                quo[i]         <= '0;
                step_cnt[i]    <= '0;
                q_neg[i]       <= 1'b0;
                r_neg[i]       <= 1'b0;
                running[i]     <= 1'b0;
                finished[i]    <= 1'b0;
                zero_div[i]    <= 1'b0;
            end
        end else begin
            thr <= (thr == TW'(THREAD_COUNT - 1)) ? '0 : thr + 1'b1;

            if (cfg_hit) begin
                signed_mode[thr] <= bus.config_signed;
            end
            if (bus.A_wren) begin
                a_latch[thr] <= bus.A;
            end

            if (bus.B_wren) begin
                if (bus.B == '0) begin
                    // Divide by zero resolves immediately: all-ones quotient, raw dividend back.
                    running[thr]  <= 1'b0;
                    finished[thr] <= 1'b1;
                    zero_div[thr] <= 1'b1;
                    quo[thr]      <= '1;
                    rem[thr]      <= dividend;
                    step_cnt[thr] <= '0;
                end else begin
                    running[thr]  <= 1'b1;
                    finished[thr] <= 1'b0;
                    zero_div[thr] <= 1'b0;
                    quo[thr]      <= a_mag;
                    rem[thr]      <= '0;
                    divisor[thr]  <= b_mag;
                    step_cnt[thr] <= CW'(W);
                    q_neg[thr]    <= a_neg ^ b_neg;
                    r_neg[thr]    <= a_neg;
                end
            end else if (running[thr]) begin
                step_cnt[thr] <= step_cnt[thr] - 1'b1;
                if (step_cnt[thr] == CW'(1)) begin
                    // Last step: store sign-corrected results; MIN/-1 wraps to MIN naturally.
                    quo[thr]      <= q_fix;
                    rem[thr]      <= r_fix;
                    running[thr]  <= 1'b0;
                    finished[thr] <= 1'b1;
                end else begin
                    quo[thr] <= quo_nx;
                    rem[thr] <= rem_nx;
                end
            end
        end
    end

    assign bus.Q           = quo[thr];
    assign bus.R           = rem[thr];
    assign bus.busy        = running[thr];
    assign bus.done        = finished[thr];
    assign bus.div_by_zero = zero_div[thr];
    assign bus.thread      = thr;
endmodule

// File: tb/tb_divider_pipeline.sv
// Bench for divider_pipeline: arithmetic reference model checked every cycle plus literal pins.
// Latency: checks results at the thread visit where they first become visible.
// Backpressure: none exercised; the design never stalls.
module tb_divider_pipeline;
    localparam int W  = 36;
    localparam int T  = 8;
    localparam int CA = 0;

    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 0;

    divider_pipeline_if #(.WORD_WIDTH(W), .THREAD_COUNT(T), .CONFIG_ADDR_WIDTH(10)) bus ();

    divider_pipeline #(
        .WORD_WIDTH(W), .THREAD_COUNT(T), .CONFIG_ADDR(CA), .CONFIG_ADDR_WIDTH(10)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Reference model: expected results from plain / and %, per-thread visit countdown.
    int           m_thr;
    logic         m_signed [T];
    logic [W-1:0] m_alat   [T];
    logic [W-1:0] m_q      [T];
    logic [W-1:0] m_r      [T];
    logic         m_busy   [T];
    logic         m_done   [T];
    logic         m_dbz    [T];
    int           m_left   [T];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        int           t;
        logic         old_s;
        logic [W-1:0] dvd;
        longint       sa;
        longint       sb;
        t = m_thr;
        if (!reset_n) begin
            for (int i = 0; i < T; i++) begin
                m_signed[i] = 0; m_alat[i] = '0; m_q[i] = '0; m_r[i] = '0;
                m_busy[i] = 0; m_done[i] = 0; m_dbz[i] = 0; m_left[i] = 0;
            end
            m_thr = 0;
            return;
        end
        old_s = m_signed[t];
        if (bus.config_enable && bus.config_addr == 10'(CA)) m_signed[t] = bus.config_signed;
        dvd = bus.A_wren ? bus.A : m_alat[t];
        if (bus.A_wren) m_alat[t] = bus.A;
        if (bus.B_wren) begin
            if (bus.B == '0) begin
                m_busy[t] = 0; m_done[t] = 1; m_dbz[t] = 1; m_q[t] = '1; m_r[t] = dvd;
            end else begin
                m_busy[t] = 1; m_done[t] = 0; m_dbz[t] = 0; m_left[t] = W;
                if (old_s) begin
                    sa = $signed(dvd);
                    sb = $signed(bus.B);
                    m_q[t] = W'(sa / sb);
                    m_r[t] = W'(sa % sb);
                end else begin
                    m_q[t] = dvd / bus.B;
                    m_r[t] = dvd % bus.B;
                end
            end
        end else if (m_busy[t]) begin
            m_left[t]--;
            if (m_left[t] == 0) begin
                m_busy[t] = 0; m_done[t] = 1;
            end
        end
        m_thr = (m_thr + 1) % T;
    endtask

    // Every-cycle comparison of the visible slot against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("thread", 64'(bus.thread), 64'(m_thr));
            chk("busy", 64'(bus.busy), 64'(m_busy[m_thr]));
            chk("done", 64'(bus.done), 64'(m_done[m_thr]));
            chk("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz[m_thr]));
            if (!m_busy[m_thr]) begin
                chk("Q", 64'(bus.Q), 64'(m_q[m_thr]));
                chk("R", 64'(bus.R), 64'(m_r[m_thr]));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1 model_update();
        @(posedge clock);
        #1;
        bus.A_wren = 0; bus.B_wren = 0; bus.config_enable = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic to_thread(int t);
        int n = 0;
        while (m_thr != t && n < 2 * T) begin tick(); n++; end
    endtask

    task automatic go(int t, logic [W-1:0] a, bit aw, logic [W-1:0] b, bit bw, bit ce, bit cs);
        to_thread(t);
        bus.A = a; bus.A_wren = aw; bus.B = b; bus.B_wren = bw;
        bus.config_enable = ce; bus.config_signed = cs;
        tick();
    endtask

    task automatic pin(string name, int t, logic [W-1:0] q, logic [W-1:0] r);
        chk({name, "_thread"}, 64'(bus.thread), 64'(t));
        chk({name, "_done"}, 64'(bus.done), 64'd1);
        chk({name, "_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "_Q"}, 64'(bus.Q), 64'(q));
        chk({name, "_R"}, 64'(bus.R), 64'(r));
    endtask

    initial begin
        bus.config_addr = '0; bus.config_signed = 0; bus.config_enable = 0;
        bus.A = '0; bus.A_wren = 0; bus.B = '0; bus.B_wren = 0;
        m_thr = 0;
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        chk_en = 1;
        chk("rst_thread", 64'(bus.thread), 64'd0);
        chk("rst_Q", 64'(bus.Q), 64'd0);
        chk("rst_R", 64'(bus.R), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);

        // Thread 0 unsigned 100/7, started in cycle 0, result at cycle 296.
        go(0, 36'd100, 1, 36'd7, 1, 0, 0);
        idle(7);
        chk("t0_visit1_busy", 64'(bus.busy), 64'd1);
        idle(288);
        pin("t0_100div7", 0, 36'd14, 36'd2);
        chk("model_q0", 64'(m_q[0]), 64'd14);

        // Thread 3 signed: -7/2 then 7/-2.
        go(3, '0, 0, '0, 0, 1, 1);
        go(3, 36'hFFFFFFFF9, 1, 36'd2, 1, 0, 0);
        idle(295);
        pin("t3_m7div2", 3, 36'hFFFFFFFFD, 36'hFFFFFFFFF);
        chk("model_r3", 64'(m_r[3]), 64'hFFFFFFFFF);
        go(3, 36'd7, 1, 36'hFFFFFFFFE, 1, 0, 0);
        idle(295);
        pin("t3_7divm2", 3, 36'hFFFFFFFFD, 36'd1);

        // Thread 5 divide by zero, then a restart from the latched dividend.
        go(5, 36'd55, 1, 36'd0, 1, 0, 0);
        idle(7);
        pin("t5_dbz", 5, 36'hFFFFFFFFF, 36'd55);
        chk("t5_dbz_flag", 64'(bus.div_by_zero), 64'd1);
        go(5, '0, 0, 36'd5, 1, 0, 0);
        idle(7);
        chk("t5_dbz_clear", 64'(bus.div_by_zero), 64'd0);
        chk("t5_restart_busy", 64'(bus.busy), 64'd1);

        // Unsigned all-ones/1 on thread 1, signed MIN/-1 on thread 3.
        go(1, 36'hFFFFFFFFF, 1, 36'd1, 1, 0, 0);
        go(3, 36'h800000000, 1, 36'hFFFFFFFFF, 1, 0, 0);
        idle(293);
        pin("t1_max_div1", 1, 36'hFFFFFFFFF, 36'd0);
        to_thread(3);
        pin("t3_min_divm1", 3, 36'h800000000, 36'd0);

        // All threads back to back, thread 2 restarted at its visit 10.
        to_thread(0);
        for (int t = 0; t < T; t++) go(t, 36'(1000 * (t + 1) + 37 * t), 1, 36'(t + 3), 1, 0, 0);
        idle(72);
        go(2, 36'd123456789, 1, 36'd1000, 1, 0, 0);
        idle(295);
        pin("t2_restart", 2, 36'd123456, 36'd789);
        idle(16);

        // Reset mid-division, then starts in default unsigned mode.
        go(4, 36'd5000, 1, 36'd7, 1, 0, 0);
        idle(20);
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("rst2_thread", 64'(bus.thread), 64'd0);
        chk("rst2_busy", 64'(bus.busy), 64'd0);
        chk("rst2_Q", 64'(bus.Q), 64'd0);
        idle(8);
        go(3, 36'hFFFFFFFF0, 1, 36'd2, 1, 0, 0);
        go(6, 36'hFFFFFFFFC, 1, 36'd2, 1, 1, 1);
        idle(292);
        pin("t3_after_rst", 3, 36'h7FFFFFFF8, 36'd0);
        to_thread(6);
        pin("t6_cfg_same_cycle", 6, 36'h7FFFFFFFE, 36'd0);
        idle(2);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
